// File: rtl/pulse_sequencer.sv
// Multi-channel pulse timing generator.
// Each of N_CH outputs is high for a window [offset, offset+length) inside a
// repeating period of repeat_period+1 cycles. Supports burst counting,
// externally triggered periods, start/stop control and shadowed configuration
// that only changes at period boundaries (or immediately while idle).
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   repeat_period   period P (P+1 cycles per period)
//   ch_offset       per-channel offset, channel i at [i*N_BITS +: N_BITS]
//   ch_length       per-channel high length, same packing
//   ch_enable       per-channel enable
//   burst_count     periods per run, 0 = continuous
//   trig_mode       1 = each period waits for an ext_trigger rising edge
//   ext_trigger     external trigger, synchronous to clk
//   start/stop/load one-cycle control pulses
//   out             registered channel outputs
//   busy            high while armed or running
//   period_start    first cycle of each period
//   done            one-cycle pulse when a burst completes
//   overrun         sticky: trigger edge seen while running in trig_mode
module pulse_sequencer #(
    parameter int unsigned N_BITS       = 20,
    parameter int unsigned N_CH         = 5,
    parameter int unsigned N_BURST_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BITS-1:0]        repeat_period,
    input  logic [N_CH*N_BITS-1:0]   ch_offset,
    input  logic [N_CH*N_BITS-1:0]   ch_length,
    input  logic [N_CH-1:0]          ch_enable,
    input  logic [N_BURST_BITS-1:0]  burst_count,
    input  logic                     trig_mode,
    input  logic                     ext_trigger,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     load,
    output logic [N_CH-1:0]          out,
    output logic                     busy,
    output logic                     period_start,
    output logic                     done,
    output logic                     overrun
);

    typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

    localparam logic [N_BITS-1:0]       CountOne = 1;
    localparam logic [N_BURST_BITS-1:0] BurstOne = 1;

    state_e                    state_q, state_d;
    logic [N_BITS-1:0]         count_q, count_d;
    logic [N_BURST_BITS-1:0]   periods_q, periods_d;
    logic [N_CH-1:0]           out_q, out_d;
    logic                      done_q, done_d;
    logic                      overrun_q, overrun_d;
    logic                      load_pending_q, load_pending_d;
    logic                      trig_prev_q;

    logic [N_BITS-1:0]         sh_period_q;
    logic [N_CH*N_BITS-1:0]    sh_offset_q;
    logic [N_CH*N_BITS-1:0]    sh_length_q;
    logic [N_CH-1:0]           sh_enable_q;
    logic [N_BURST_BITS-1:0]   sh_burst_q;
    logic                      sh_trig_mode_q;

    logic                      in_run, at_end, burst_fin, trig_edge, start_ok, capture;
    logic [N_CH-1:0]           win;

    assign in_run    = (state_q == StRun);
    assign at_end    = in_run && (count_q == sh_period_q);
    assign burst_fin = (sh_burst_q != '0) && ((periods_q + BurstOne) == sh_burst_q);
    assign trig_edge = ext_trigger & ~trig_prev_q;
    assign start_ok  = (state_q == StIdle) && start && !stop;
    // Shadow follows live inputs when idle; otherwise only at the period wrap.
    assign capture   = ((state_q == StIdle) && (start_ok || load)) ||
                       (at_end && (load_pending_q || load));

    // End of window is computed one bit wider so offset+length never wraps.
    always_comb begin
        win = '0;
        for (int i = 0; i < N_CH; i++) begin
            win[i] = sh_enable_q[i] & in_run &
                     (count_q >= sh_offset_q[i*N_BITS +: N_BITS]) &
                     ({1'b0, count_q} < ({1'b0, sh_offset_q[i*N_BITS +: N_BITS]} +
                                         {1'b0, sh_length_q[i*N_BITS +: N_BITS]}));
        end
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        periods_d      = periods_q;
        done_d         = 1'b0;
        overrun_d      = overrun_q;
        load_pending_d = load_pending_q;
        out_d          = stop ? '0 : win;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = trig_mode ? StArmed : StRun;
                    count_d   = '0;
                    periods_d = '0;
                end
            end
            StArmed: begin
                if (trig_edge) begin
                    state_d = StRun;
                    count_d = '0;
                end
            end
            StRun: begin
                if (at_end) begin
                    periods_d = periods_q + BurstOne;
                    count_d   = '0;
                    if (burst_fin) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (sh_trig_mode_q) begin
                        state_d = StArmed;
                    end
                end else begin
                    count_d = count_q + CountOne;
                end
            end
            default: state_d = StIdle;
        endcase

        if (stop) begin
            state_d = StIdle;
            count_d = '0;
            done_d  = 1'b0;
        end

        if (start_ok) begin
            overrun_d = 1'b0;
        end
        if (trig_edge && in_run && sh_trig_mode_q) begin
            overrun_d = 1'b1;
        end

        if (capture) begin
            load_pending_d = 1'b0;
        end else if (load) begin
            load_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            count_q        <= '0;
            periods_q      <= '0;
            out_q          <= '0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
            load_pending_q <= 1'b0;
            trig_prev_q    <= 1'b0;
            sh_period_q    <= '0;
            sh_offset_q    <= '0;
            sh_length_q    <= '0;
            sh_enable_q    <= '0;
            sh_burst_q     <= '0;
            sh_trig_mode_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            periods_q      <= periods_d;
            out_q          <= out_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
            load_pending_q <= load_pending_d;
            trig_prev_q    <= ext_trigger;
            if (capture) begin
                sh_period_q    <= repeat_period;
                sh_offset_q    <= ch_offset;
                sh_length_q    <= ch_length;
                sh_enable_q    <= ch_enable;
                sh_burst_q     <= burst_count;
                sh_trig_mode_q <= trig_mode;
            end
        end
    end

    assign out          = out_q;
    assign busy         = (state_q != StIdle);
    assign period_start = in_run && (count_q == '0);
    assign done         = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Testbench for pulse_sequencer: a behavioural model (positions, windows and
// burst counts in plain integers) is checked against the DUT every cycle,
// alongside directed scenarios with hand-computed expectations, followed by
// a randomized phase.
module tb_pulse_sequencer;

    localparam int NB  = 20;
    localparam int NC  = 5;
    localparam int NBB = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NB-1:0]   repeat_period = '0;
    logic [NC*NB-1:0] ch_offset = '0;
    logic [NC*NB-1:0] ch_length = '0;
    logic [NC-1:0]   ch_enable = '0;
    logic [NBB-1:0]  burst_count = '0;
    logic            trig_mode = 1'b0;
    logic            ext_trigger = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            load = 1'b0;
    logic [NC-1:0]   out;
    logic            busy, period_start, done, overrun;

    always #5 clk = ~clk;

    pulse_sequencer #(.N_BITS(NB), .N_CH(NC), .N_BURST_BITS(NBB)) dut (
        .clk(clk), .reset(reset), .repeat_period(repeat_period),
        .ch_offset(ch_offset), .ch_length(ch_length), .ch_enable(ch_enable),
        .burst_count(burst_count), .trig_mode(trig_mode), .ext_trigger(ext_trigger),
        .start(start), .stop(stop), .load(load), .out(out), .busy(busy),
        .period_start(period_start), .done(done), .overrun(overrun)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: mode 0 idle, 1 waiting for trigger, 2 running.
    int            m_mode, m_pos, m_periods;
    logic [NC-1:0] m_out;
    bit            m_done, m_ovr, m_pend, m_prev;
    int            s_p, s_burst;
    int            s_off[NC];
    int            s_len[NC];
    bit [NC-1:0]   s_en;
    bit            s_trig;

    task automatic capture_live();
        s_p     = int'(repeat_period);
        s_burst = int'(burst_count);
        s_en    = ch_enable;
        s_trig  = trig_mode;
        for (int i = 0; i < NC; i++) begin
            s_off[i] = int'(ch_offset[i*NB +: NB]);
            s_len[i] = int'(ch_length[i*NB +: NB]);
        end
    endtask

    task automatic model_step();
        bit trg_edge, period_end, accepted, cap;
        logic [NC-1:0] win;
        if (reset) begin
            m_mode = 0; m_pos = 0; m_periods = 0; m_out = '0;
            m_done = 0; m_ovr = 0; m_pend = 0; m_prev = 0;
            s_p = 0; s_burst = 0; s_en = '0; s_trig = 0;
            for (int i = 0; i < NC; i++) begin
                s_off[i] = 0;
                s_len[i] = 0;
            end
            return;
        end
        trg_edge   = ext_trigger && !m_prev;
        period_end = (m_mode == 2) && (m_pos == s_p);
        accepted   = (m_mode == 0) && start && !stop;
        for (int i = 0; i < NC; i++)
            win[i] = s_en[i] && (m_mode == 2) && (m_pos >= s_off[i]) &&
                     (m_pos < s_off[i] + s_len[i]);
        cap = ((m_mode == 0) && (accepted || load)) || (period_end && (m_pend || load));
        if (accepted) m_ovr = 0;
        if (trg_edge && (m_mode == 2) && s_trig) m_ovr = 1;
        m_done = 0;
        if (stop) begin
            m_mode = 0;
            m_pos  = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = trig_mode ? 1 : 2;
                m_pos = 0;
                m_periods = 0;
            end
        end else if (m_mode == 1) begin
            if (trg_edge) begin
                m_mode = 2;
                m_pos = 0;
            end
        end else if (period_end) begin
            if ((s_burst != 0) && (m_periods + 1 == s_burst)) begin
                m_mode = 0;
                m_done = 1;
            end else if (s_trig) begin
                m_mode = 1;
            end
            m_pos = 0;
            m_periods++;
        end else begin
            m_pos++;
        end
        m_out  = stop ? '0 : win;
        m_pend = cap ? 1'b0 : (load ? 1'b1 : m_pend);
        if (cap) capture_live();
        m_prev = ext_trigger;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every cycle once the first reset has been applied.
    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            check("out", 32'(out), 32'(m_out));
            check("busy", 32'(busy), 32'(m_mode != 0));
            check("period_start", 32'(period_start), 32'((m_mode == 2) && (m_pos == 0)));
            check("done", 32'(done), 32'(m_done));
            check("overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0; step();
    endtask

    task automatic set_ch(input int i, input int off, input int len);
        ch_offset[i*NB +: NB] = NB'(off);
        ch_length[i*NB +: NB] = NB'(len);
    endtask

    task automatic config_base(input int p, input int burst, input bit trig, input int en);
        repeat_period = NB'(p);
        burst_count   = NBB'(burst);
        trig_mode     = trig;
        ch_enable     = NC'(en);
        ch_offset     = '0;
        ch_length     = '0;
    endtask

    initial begin : stim
        int ps_cnt;

        reset = 1'b1; step(); step();
        cmp_on = 1'b1;
        check("reset_out", 32'(out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0; step();

        // Free-run P=9: ch0 [0,3), ch1 [4,6), outputs one cycle late.
        config_base(9, 0, 0, 3); set_ch(0, 0, 3); set_ch(1, 4, 2);
        pulse_start();
        for (int c = 0; c < 20; c++) begin
            check("fr_ch0", 32'(out[0]), 32'((c % 10 >= 1) && (c % 10 <= 3)));
            check("fr_ch1", 32'(out[1]), 32'((c % 10 >= 5) && (c % 10 <= 6)));
            check("fr_ps", 32'(period_start), 32'(c % 10 == 0));
            step();
        end
        pulse_stop();

        // Burst of 3 periods with P=4 -> done 15 cycles after run begins.
        config_base(4, 3, 0, 1); set_ch(0, 1, 2);
        pulse_start();
        ps_cnt = 0;
        for (int c = 0; c < 19; c++) begin
            if (period_start) ps_cnt++;
            if (c == 14) check("burst_busy_last", 32'(busy), 32'd1);
            if (c == 14) check("burst_done_early", 32'(done), 32'd0);
            if (c == 15) check("burst_done", 32'(done), 32'd1);
            if (c == 15) check("burst_idle", 32'(busy), 32'd0);
            if (c >= 16) check("burst_out_after", 32'(out), 32'd0);
            if (c == 16) check("burst_done_once", 32'(done), 32'd0);
            step();
        end
        check("burst_periods", 32'(ps_cnt), 32'd3);

        // Triggered mode P=7: wait, trigger, overrun on second edge.
        config_base(7, 0, 1, 1); set_ch(0, 0, 2);
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            check("armed_out", 32'(out), 32'd0);
            check("armed_busy", 32'(busy), 32'd1);
            step();
        end
        ext_trigger = 1'b1; step(); ext_trigger = 1'b0;
        check("trig_ps", 32'(period_start), 32'd1);
        step(); step(); step();
        ext_trigger = 1'b1; step(); ext_trigger = 1'b0;
        check("trig_overrun", 32'(overrun), 32'd1);
        step(); step(); step(); step();
        check("rearmed_busy", 32'(busy), 32'd1);
        check("rearmed_ps", 32'(period_start), 32'd0);
        step(); step();
        ext_trigger = 1'b1; step(); ext_trigger = 1'b0;
        check("retrig_ps", 32'(period_start), 32'd1);
        pulse_stop();
        trig_mode = 1'b0;
        pulse_start();
        check("overrun_cleared", 32'(overrun), 32'd0);
        pulse_stop();

        // Shadowed load mid-period: length 3 now, 6 from next period.
        config_base(9, 0, 0, 1); set_ch(0, 0, 3);
        pulse_start();
        for (int c = 0; c < 20; c++) begin
            if (c < 11) check("load_old", 32'(out[0]), 32'((c >= 1) && (c <= 3)));
            else        check("load_new", 32'(out[0]), 32'((c - 10 >= 1) && (c - 10 <= 6)));
            if (c == 2) begin
                set_ch(0, 0, 6);
                load = 1'b1; step(); load = 1'b0;
            end else begin
                step();
            end
        end
        pulse_stop();

        // Stop while ch0 is high; then start+stop together while idle.
        config_base(9, 0, 0, 1); set_ch(0, 4, 4);
        pulse_start();
        repeat (5) step();
        check("stop_pre_high", 32'(out[0]), 32'd1);
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_out", 32'(out), 32'd0);
        check("stop_idle", 32'(busy), 32'd0);
        check("stop_nodone", 32'(done), 32'd0);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("startstop_idle", 32'(busy), 32'd0);
        step();
        check("startstop_idle2", 32'(busy), 32'd0);

        // Offset beyond P and zero length never assert; ch2 [0,1) does.
        config_base(5, 0, 0, 7); set_ch(0, 6, 3); set_ch(1, 2, 0); set_ch(2, 0, 1);
        pulse_start();
        for (int c = 0; c < 14; c++) begin
            check("never_high", 32'(out[1:0]), 32'd0);
            step();
        end
        pulse_stop();

        // P=0: every cycle is a period; ch0 [0,1) stays high.
        config_base(0, 0, 0, 1); set_ch(0, 0, 1);
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            check("p0_ps", 32'(period_start), 32'd1);
            if (c >= 1) check("p0_out", 32'(out[0]), 32'd1);
            step();
        end

        // Reset mid-run after an overrun.
        pulse_stop();
        config_base(7, 0, 1, 1); set_ch(0, 0, 4);
        pulse_start();
        ext_trigger = 1'b1; step(); ext_trigger = 1'b0; step();
        ext_trigger = 1'b1; step(); ext_trigger = 1'b0;
        check("pre_reset_ovr", 32'(overrun), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_out", 32'(out), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();

        // Randomized phase against the model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 7) == 0) begin
                repeat_period = NB'($urandom_range(0, 12));
                burst_count   = NBB'($urandom_range(0, 4));
                trig_mode     = 1'($urandom_range(0, 1));
                ch_enable     = NC'($urandom);
                for (int i = 0; i < NC; i++)
                    set_ch(i, int'($urandom_range(0, 14)), int'($urandom_range(0, 14)));
            end
            if ($urandom_range(0, 3) == 0) ext_trigger = ~ext_trigger;
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 149) == 0);
            load  = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 799) == 0);
            step();
        end
        start = 1'b0; stop = 1'b0; load = 1'b0; reset = 1'b0;
        step();
        cmp_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Multi-channel, parametrised pulse timing generator for the laser/camera controller. N_CH independent outputs, each high for a programmable window (offset, length) within a repeating period. Adds burst counting, an externally triggered mode, start/stop control and glitch-free shadowed configuration updates at period boundaries. Sits between the host register file and the laser/camera output pins.

Parameters:
N_BITS, 20, width of period/offset/length counters
N_CH, 5, number of output channels
N_BURST_BITS, 16, width of burst counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
repeat_period  in  N_BITS  period P; one period = P+1 cycles
ch_offset  in  N_CH*N_BITS  per-channel start offset, channel i at [i*N_BITS +: N_BITS]
ch_length  in  N_CH*N_BITS  per-channel high length in cycles, same packing
ch_enable  in  N_CH  per-channel enable
burst_count  in  N_BURST_BITS  periods per run; 0 = continuous
trig_mode  in  1  0 = free-run, 1 = each period waits for ext_trigger
ext_trigger  in  1  synchronous to clk; rising edge starts a period in trig_mode
start  in  1  one-cycle pulse, begins run
stop  in  1  one-cycle pulse, aborts run
load  in  1  one-cycle pulse, request config update
out  out  N_CH  channel pulse outputs (registered)
busy  out  1  high in ARMED or RUN
period_start  out  1  one-cycle pulse, first cycle of each period
done  out  1  one-cycle pulse when burst completes
overrun  out  1  sticky: trigger edge arrived while RUN; cleared by start or reset

Behaviour:
- Reset (sync, highest priority): state IDLE, count 0, burst counter 0, all outputs 0, overrun 0, load_pending 0, shadow regs 0.
- Shadow regs hold repeat_period, ch_offset, ch_length, ch_enable, burst_count, trig_mode. Captured on start in IDLE. load sets load_pending; shadow recaptured on the cycle count wraps (and load_pending cleared) or immediately if IDLE. Mid-period changes to live inputs never affect outputs.
- States: IDLE -> (start) RUN if shadow trig_mode=0, else ARMED. ARMED -> (ext_trigger rising edge) RUN. RUN at count=P: if burst finished -> IDLE + done; else if trig_mode -> ARMED; else count<=0, stay RUN.
- stop in any state -> IDLE next cycle, out all 0 next cycle, no done. stop beats start in same cycle. start ignored while busy.
- count: 0..P in RUN, +1 per cycle. period_start high when count=0 in RUN.
- Channel i combinational condition: ch_enable[i] & RUN & (count >= off_i) & (count < off_i+len_i), sum in N_BITS+1 bits (no wrap). out is that value registered: one-cycle latency from count. Windows extending past P truncate at period end; len=0 never high; off>P never high.
- Burst: periods counter increments at each count=P; finish when counter+1 == burst_count (nonzero). burst_count=0 runs until stop.
- Trigger edge detect: registered ext_trigger, edge = ext_trigger & ~prev. Edge in RUN (trig_mode) ignored and sets overrun. Edge in IDLE ignored.
- P=0: one-cycle periods; channel with off=0, len>=1 stays high continuously in free-run.

Test Plan:
- Free-run, P=9, ch0 off=0 len=3, ch1 off=4 len=2, burst=0, start -> ch0 high cycles 1-3, ch1 high 5-6 after start (one-cycle latency), repeating every 10 cycles; period_start every 10.
- Burst=3, P=4 -> exactly 3 periods, done pulses once 15 cycles after run begins, busy drops same cycle as done, outputs 0 thereafter.
- trig_mode=1, P=7 -> no output until ext_trigger edge; second edge 3 cycles into period ignored, overrun=1; next edge after return to ARMED starts new period.
- Change ch_length 3->6 and pulse load mid-period at count=2 -> current period keeps len 3, next period len 6.
- stop at count=5 with ch0 high (off=4 len=4) -> ch0 low next cycle, state IDLE, no done; simultaneous start+stop in IDLE stays IDLE.
- Reset asserted mid-run -> all outputs, overrun, busy 0 next edge; ch off=P+1 or len=0 never asserts.
